control_acceso: RTL and testbench
=================================

Name: control_acceso

Overview:
Access-control sequencer that wraps the hand-sanitiser dispenser stage. It enables the dispenser (`G`) when a person is at the entrance and occupancy is below capacity. It consumes the dispenser's confirmation (`G2`), opens the door after a qualified disinfection, and raises an alarm if disinfection does not happen in time. It also keeps the room occupancy count using an exit sensor.

Parameters:
- TICK_DIV, 50000, clk cycles per internal timebase tick (1 ms at 50 MHz).
- DISP_MIN, 200, consecutive ticks `G2` must be high to qualify a disinfection.
- T_ESPERA, 10000, ticks allowed in HABILITA before rejection.
- T_ABRE, 3000, ticks the door stays open.
- T_ALARMA, 2000, ticks the alarm stays asserted.
- CAP, 20, maximum occupancy.
- AW, 5, width of the occupancy counter; must satisfy 2^AW > CAP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pres_ent  in  1  entrance presence sensor, active high, asynchronous.
- G2  in  1  disinfection confirmation from the dispenser, active high, asynchronous to this block's logic.
- sal  in  1  exit sensor, active high pulse per person leaving, asynchronous.
- G  out  1  dispenser enable.
- puerta  out  1  door open command.
- alarma  out  1  rejection alarm.
- lleno  out  1  occupancy equals CAP.
- aforo  out  AW  current occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything immediately:
  - outputs: G=0, puerta=0, alarma=0, lleno=0, aforo=0;
  - internals: FSM=IDLE, prescaler=0, all timers=0, synchronisers=0.
- Input synchronisation: pres_ent, G2 and sal each pass through a 2-FF synchroniser. Their synchronised versions are pres_s, g2_s and sal_s.
- Exit edge: sal_s gets a rising-edge detector evaluated every clk. Each edge is one exit event.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for exactly one clk when count==TICK_DIV-1. The first tick occurs TICK_DIV clks after reset release.
- FSM state changes and all timers (cnt_disp, cnt_t) advance only on tick cycles. The occupancy counter updates on any clk.
- All outputs are registered and decoded from the next state, so each output changes in the same clk as the state changes.
- FSM states:
  - IDLE: G=0, puerta=0, alarma=0.
    - On tick with pres_s=1 and lleno=0 -> HABILITA; clear cnt_disp and cnt_t.
    - If lleno=1, remain in IDLE regardless of pres_s.
  - HABILITA: G=1. On each tick:
    - cnt_t increments.
    - cnt_disp increments if g2_s=1, otherwise clears to 0.
    - If cnt_disp reaches DISP_MIN -> ABRE. This takes priority over timeout on the same tick.
    - Else if cnt_t reaches T_ESPERA -> RECHAZO.
    - Else if pres_s=0 -> IDLE, with no alarm (person left).
  - ABRE: puerta=1, G=0. aforo increments by 1 in the clk of entry.
    - After T_ABRE ticks -> LIBERA.
    - pres_s dropping during ABRE does not shorten the open time.
  - RECHAZO: alarma=1, G=0.
    - After T_ALARMA ticks -> LIBERA.
  - LIBERA: all outputs low.
    - On tick with pres_s=0 -> IDLE. Waiting for the entrance to clear prevents re-triggering on the same person.
- Occupancy counter:
  - Each exit event decrements aforo if aforo>0; it saturates at 0.
  - An increment (entry into ABRE) and a decrement in the same clk leave aforo unchanged.
  - An increment never occurs at CAP, because the FSM only leaves IDLE when lleno=0.
  - lleno is registered and equals (aforo_next==CAP).
- Mid-operation reset: any state returns to IDLE immediately with outputs low and aforo=0.

Test Plan:
All scenarios use TICK_DIV=4, DISP_MIN=3, T_ESPERA=10, T_ABRE=5, T_ALARMA=4, CAP=2.
1. Normal entry: pres_ent=1, then G2=1 held.
   - G rises at the first tick.
   - G falls and puerta rises on the 3rd tick with g2_s=1.
   - aforo goes 0->1.
   - puerta stays high for 5 ticks; the FSM then sits in LIBERA until pres_ent=0.
2. Interrupted disinfection: G2 high 2 ticks, low 1 tick, high 3 ticks -> ABRE only after the second run of 3; cnt_disp restarts at the low tick.
3. Timeout: pres_ent=1, G2=0 for 10 ticks -> G falls and alarma=1 for 4 ticks; aforo unchanged.
4. Capacity: two successful entries -> aforo=2 and lleno=1. A third pres_ent keeps G=0. One sal pulse -> aforo=1, lleno=0, and the next tick enters HABILITA.
5. Simultaneous events:
   - A sal edge in the same clk as entry into ABRE at aforo=1 -> aforo stays 1.
   - A sal edge at aforo=0 -> aforo stays 0.
6. Async reset asserted mid-ABRE with aforo=1 -> puerta=0, aforo=0, state IDLE with no clk edge required. The first tick after release occurs 4 clks later.

Source files
------------

// File: rtl/control_acceso.sv
// control_acceso: entrance sequencer driving the sanitiser, door, alarm and occupancy count
// Ports: clk, rst_n (async, active low); pres_ent/G2/sal raw async sensors;
//        G dispenser enable, puerta door open, alarma rejection alarm,
//        lleno room full, aforo current occupancy.
module control_acceso #(
  parameter int TICK_DIV = 50000,
  parameter int DISP_MIN = 200,
  parameter int T_ESPERA = 10000,
  parameter int T_ABRE   = 3000,
  parameter int T_ALARMA = 2000,
  parameter int CAP      = 20,
  parameter int AW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pres_ent,
  input  logic          G2,
  input  logic          sal,
  output logic          G,
  output logic          puerta,
  output logic          alarma,
  output logic          lleno,
  output logic [AW-1:0] aforo
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = T_ESPERA > T_ABRE ? (T_ESPERA > T_ALARMA ? T_ESPERA : T_ALARMA)
                                          : (T_ABRE > T_ALARMA ? T_ABRE : T_ALARMA);
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = $clog2(DISP_MIN + 1);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HABILITA = 3'd1;
  localparam logic [2:0] ABRE     = 3'd2;
  localparam logic [2:0] RECHAZO  = 3'd3;
  localparam logic [2:0] LIBERA   = 3'd4;
  logic pres_m, pres_s, g2_m, g2_s, sal_m, sal_s, sal_d;
  logic [PW-1:0] pre;
  logic [TW-1:0] cnt_t, cnt_t_n, t_inc;
  logic [DW-1:0] cnt_disp, cnt_disp_n, d_inc;
  logic [2:0] st, st_n;
  logic tick, ev, inc, dec;
  logic [AW-1:0] aforo_n;
  assign tick  = pre == PW'(TICK_DIV - 1);
  assign ev    = sal_s & ~sal_d;
  assign t_inc = cnt_t + 1'b1;
  // a low g2_s tick breaks the run, so only DISP_MIN consecutive ticks qualify
  assign d_inc = g2_s ? cnt_disp + 1'b1 : '0;
  always_comb begin
    st_n       = st;
    cnt_t_n    = cnt_t;
    cnt_disp_n = cnt_disp;
    if (tick)
      case (st)
        IDLE: if (pres_s && !lleno) begin
          st_n       = HABILITA;
          cnt_t_n    = '0;
          cnt_disp_n = '0;
        end
        HABILITA: begin
          cnt_t_n    = t_inc;
          cnt_disp_n = d_inc;
          if (d_inc == DW'(DISP_MIN)) begin
            st_n    = ABRE;
            cnt_t_n = '0;
          end else if (t_inc == TW'(T_ESPERA)) begin
            st_n    = RECHAZO;
            cnt_t_n = '0;
          end else if (!pres_s) st_n = IDLE;
        end
        ABRE: begin
          cnt_t_n = t_inc;
          st_n    = t_inc == TW'(T_ABRE) ? LIBERA : ABRE;
        end
        RECHAZO: begin
          cnt_t_n = t_inc;
          st_n    = t_inc == TW'(T_ALARMA) ? LIBERA : RECHAZO;
        end
        LIBERA: st_n = pres_s ? LIBERA : IDLE;
        default: st_n = IDLE;
      endcase
  end
  // entry into ABRE and an exit in the same clk cancel out
  assign inc     = st_n == ABRE && st != ABRE;
  assign dec     = ev && aforo != '0;
  assign aforo_n = aforo + AW'(inc) - AW'(dec);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {pres_m, pres_s, g2_m, g2_s, sal_m, sal_s, sal_d} <= '0;
      pre      <= '0;
      st       <= IDLE;
      cnt_t    <= '0;
      cnt_disp <= '0;
      aforo    <= '0;
      lleno    <= 1'b0;
      G        <= 1'b0;
      puerta   <= 1'b0;
      alarma   <= 1'b0;
    end else begin
      {pres_s, pres_m} <= {pres_m, pres_ent};
      {g2_s, g2_m}     <= {g2_m, G2};
      {sal_s, sal_m}   <= {sal_m, sal};
      sal_d    <= sal_s;
      pre      <= tick ? '0 : pre + 1'b1;
      st       <= st_n;
      cnt_t    <= cnt_t_n;
      cnt_disp <= cnt_disp_n;
      aforo    <= aforo_n;
      lleno    <= aforo_n == AW'(CAP);
      G        <= st_n == HABILITA;
      puerta   <= st_n == ABRE;
      alarma   <= st_n == RECHAZO;
    end
endmodule

// File: tb/tb_control_acceso.sv
// tb_control_acceso: randomized and directed checks of control_acceso against a behavioural model
module tb_control_acceso;
  localparam int TD = 4, DM = 3, TE = 10, TA = 5, TL = 4, CAP = 2, AW = 5;
  logic clk = 0, rst_n = 0, pres_ent = 0, G2 = 0, sal = 0;
  logic G, puerta, alarma, lleno;
  logic [AW-1:0] aforo;
  int checks = 0, failures = 0;
  control_acceso #(.TICK_DIV(TD), .DISP_MIN(DM), .T_ESPERA(TE), .T_ABRE(TA),
                   .T_ALARMA(TL), .CAP(CAP), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pres_ent(pres_ent), .G2(G2), .sal(sal),
    .G(G), .puerta(puerta), .alarma(alarma), .lleno(lleno), .aforo(aforo));
  always #5 clk = ~clk;
  typedef enum {M_IDLE, M_HAB, M_ABRE, M_RECH, M_LIB} phase_t;
  phase_t ph;
  int cyc, run, waited, left, m_aforo;
  bit p1, p2, g1, g2s, s1, s2, s_prev;
  task automatic m_reset();
    ph = M_IDLE; cyc = 0; run = 0; waited = 0; left = 0; m_aforo = 0;
    {p1, p2, g1, g2s, s1, s2, s_prev} = '0;
  endtask
  // one clk of the reference: ticks come every TD clks, timers count down whole ticks
  task automatic m_step();
    bit tick, ev, dec;
    int inc;
    tick = (cyc % TD) == TD - 1;
    ev = s2 && !s_prev;
    inc = 0;
    if (tick)
      case (ph)
        M_IDLE: if (p2 && m_aforo != CAP) begin ph = M_HAB; run = 0; waited = 0; end
        M_HAB: begin
          waited++;
          run = g2s ? run + 1 : 0;
          if (run == DM) begin ph = M_ABRE; left = TA; inc = 1; end
          else if (waited == TE) begin ph = M_RECH; left = TL; end
          else if (!p2) ph = M_IDLE;
        end
        M_ABRE, M_RECH: begin left--; if (left == 0) ph = M_LIB; end
        M_LIB: if (!p2) ph = M_IDLE;
      endcase
    dec = ev && m_aforo > 0;
    m_aforo = m_aforo + inc - int'(dec);
    s_prev = s2; s2 = s1; s1 = sal;
    p2 = p1; p1 = pres_ent;
    g2s = g1; g1 = G2;
    cyc++;
  endtask
  function automatic logic [8:0] dut_v();
    return {G, puerta, alarma, lleno, aforo};
  endfunction
  function automatic logic [8:0] mdl_v();
    return {ph == M_HAB, ph == M_ABRE, ph == M_RECH, m_aforo == CAP, AW'(m_aforo)};
  endfunction
  task automatic step();
    @(posedge clk);
    if (rst_n) m_step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    pres_ent = 0; G2 = 0; sal = 0;
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    do_reset();
    pres_ent = 1;
    repeat (6) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL reset_pre t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
    end
    #2 rst_n = 0;
    m_reset();
    #1 checks++;
    if (dut_v() !== 9'd0) begin failures++; $display("FAIL reset_async dut=%b exp=%b", dut_v(), 9'd0); end
    do_reset();
  endtask
  task automatic test_normal_entry();
    int g_at = -1, p_on = -1, p_off = -1;
    do_reset();
    pres_ent = 1; G2 = 1;
    for (int n = 1; n <= 60; n++) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL normal_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
      if (G && g_at < 0) g_at = n;
      if (puerta && p_on < 0) p_on = n;
      if (p_on > 0 && !puerta && p_off < 0) p_off = n;
    end
    checks++; if (g_at !== 4) begin failures++; $display("FAIL normal_g_rise clk=%0d exp=4", g_at); end
    checks++; if (p_on !== 16) begin failures++; $display("FAIL normal_door_open clk=%0d exp=16", p_on); end
    checks++; if (p_off - p_on !== 20) begin failures++; $display("FAIL normal_door_len clks=%0d exp=20", p_off - p_on); end
    checks++; if (aforo !== 5'd1 || G !== 1'b0) begin failures++; $display("FAIL normal_libera aforo=%0d G=%b exp 1/0", aforo, G); end
    pres_ent = 0; G2 = 0;
    repeat (8) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL normal_exit t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
    end
  endtask
  task automatic test_interrupted();
    int p_on = -1;
    do_reset();
    pres_ent = 1;
    for (int n = 1; n <= 40; n++) begin
      G2 = !(n - 1 == 12 || n - 1 == 13);
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL interrupted_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
      if (puerta && p_on < 0) p_on = n;
    end
    checks++; if (p_on !== 28) begin failures++; $display("FAIL interrupted_open clk=%0d exp=28", p_on); end
  endtask
  task automatic test_timeout();
    int a_on = -1, a_off = -1, g_off = -1;
    do_reset();
    pres_ent = 1; G2 = 0;
    for (int n = 1; n <= 70; n++) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL timeout_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
      if (n > 4 && !G && g_off < 0) g_off = n;
      if (alarma && a_on < 0) a_on = n;
      if (a_on > 0 && !alarma && a_off < 0) a_off = n;
    end
    checks++; if (a_on !== 44 || g_off !== 44) begin failures++; $display("FAIL timeout_alarm alarm=%0d gfall=%0d exp=44", a_on, g_off); end
    checks++; if (a_off - a_on !== 16) begin failures++; $display("FAIL timeout_alarm_len clks=%0d exp=16", a_off - a_on); end
    checks++; if (aforo !== 5'd0) begin failures++; $display("FAIL timeout_aforo got=%0d exp=0", aforo); end
  endtask
  task automatic test_capacity();
    int g_seen = 0, g_wait = -1;
    do_reset();
    repeat (2) begin
      pres_ent = 1; G2 = 1;
      repeat (40) begin
        step(); checks++;
        if (dut_v() !== mdl_v()) begin failures++; $display("FAIL capacity_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
      end
      pres_ent = 0; G2 = 0;
      repeat (8) step();
    end
    checks++; if (aforo !== 5'd2 || lleno !== 1'b1) begin failures++; $display("FAIL capacity_full aforo=%0d lleno=%b exp 2/1", aforo, lleno); end
    pres_ent = 1; G2 = 1;
    repeat (16) begin step(); if (G) g_seen++; end
    checks++; if (g_seen !== 0) begin failures++; $display("FAIL capacity_blocked G_clks=%0d exp=0", g_seen); end
    sal = 1;
    repeat (3) step();
    sal = 0;
    checks++; if (aforo !== 5'd1 || lleno !== 1'b0) begin failures++; $display("FAIL capacity_exit aforo=%0d lleno=%b exp 1/0", aforo, lleno); end
    for (int n = 1; n <= 8 && g_wait < 0; n++) begin step(); if (G) g_wait = n; end
    checks++; if (g_wait < 1 || g_wait > TD) begin failures++; $display("FAIL capacity_reenter wait=%0d exp 1..%0d", g_wait, TD); end
  endtask
  task automatic test_simultaneous();
    bit found = 0;
    do_reset();
    pres_ent = 1; G2 = 1;
    repeat (40) step();
    pres_ent = 0; G2 = 0;
    repeat (8) step();
    pres_ent = 1; G2 = 1;
    for (int n = 0; n < 60 && !found; n++) begin
      if (ph == M_HAB && run == DM - 1 && cyc % TD == 1) found = 1;
      else step();
    end
    checks++; if (!found) begin failures++; $display("FAIL simult_setup found=0 exp=1"); end
    sal = 1;
    repeat (3) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL simult_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
    end
    sal = 0;
    checks++; if (puerta !== 1'b1 || aforo !== 5'd1) begin failures++; $display("FAIL simult_cancel puerta=%b aforo=%0d exp 1/1", puerta, aforo); end
    do_reset();
    sal = 1;
    repeat (4) step();
    sal = 0;
    checks++; if (aforo !== 5'd0) begin failures++; $display("FAIL simult_sat0 aforo=%0d exp=0", aforo); end
  endtask
  task automatic test_async_mid_abre();
    int g_at = -1;
    do_reset();
    pres_ent = 1; G2 = 1;
    repeat (20) step();
    checks++; if (puerta !== 1'b1 || aforo !== 5'd1) begin failures++; $display("FAIL midabre_setup puerta=%b aforo=%0d exp 1/1", puerta, aforo); end
    #2 rst_n = 0;
    m_reset();
    #1 checks++;
    if (dut_v() !== 9'd0) begin failures++; $display("FAIL midabre_reset dut=%b exp=%b", dut_v(), 9'd0); end
    @(negedge clk);
    rst_n = 1;
    for (int n = 1; n <= 8; n++) begin step(); if (G && g_at < 0) g_at = n; end
    checks++; if (g_at !== 4) begin failures++; $display("FAIL midabre_first_tick clk=%0d exp=4", g_at); end
  endtask
  task automatic test_random();
    int sal_hold = 0;
    do_reset();
    repeat (3000) begin
      if ($urandom_range(39) == 0) pres_ent = ~pres_ent;
      if ($urandom_range(19) == 0) G2 = ~G2;
      if (sal_hold > 0) sal_hold--;
      else if ($urandom_range(49) == 0) sal_hold = 2;
      sal = sal_hold > 0;
      step(); checks++;
      if (dut_v() !== mdl_v()) begin failures++; $display("FAIL random_model t=%0t dut=%b exp=%b", $time, dut_v(), mdl_v()); end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  initial begin
    m_reset();
    test_reset();
    test_normal_entry();
    test_interrupted();
    test_timeout();
    test_capacity();
    test_simultaneous();
    test_async_mid_abre();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
